bnn_layer_sequencer: RTL and testbench

Instruction sequencer for one binary layer pass of the BNN core. On `start` it latches a layer configuration and issues the 20-bit core instruction word cycle by cycle:
- configuration load, bias load, accumulator clear, image/weight loads, partial-sum accumulation per BPU group, binarisation (with optional 2x2 OR-pooling) and result readout.
- It sits between the layer-level control FSM / input stream and the core's `instruction`/`data_in` pins.

---
 rtl/bnn_layer_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_bnn_layer_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_layer_sequencer.sv
// Instruction sequencer for one binary layer pass of the BNN core.
// Issues the 20-bit core instruction word and data_in value cycle by cycle.
module bnn_layer_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] cfg_enable,
  input  logic [2:0]  cfg_height,
  input  logic [3:0]  cfg_groups,
  input  logic [2:0]  cfg_pixels,
  input  logic [3:0]  cfg_load_beats,
  input  logic        cfg_pool,
  input  logic [2:0]  cfg_wgt_sel,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [31:0] core_data,
  output logic [19:0] instruction,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_BIAS, S_CLR, S_LOAD, S_ACC, S_BIN, S_STORE, S_DONE
  } state_e;

  state_e      state_q, state_d;

  // k serves as the beat index in BIAS/LOAD and the half index in STORE.
  logic [3:0]  k_q, k_d;
  logic [3:0]  g_q, g_d;
  logic [1:0]  w_q, w_d;
  logic [2:0]  p_q, p_d;

  logic [15:0] enable_q;
  logic [2:0]  height_q;
  logic [3:0]  groups_q;
  logic [2:0]  pixels_q;
  logic [3:0]  last_beat_q;
  logic        pool_q;
  logic [2:0]  wgt_sel_q;

  logic        accept_start;
  logic        in_xfer;

  assign accept_start = (state_q == S_IDLE) && start;
  assign in_xfer      = in_valid && in_ready;
  assign busy         = (state_q != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      g_q     <= '0;
      w_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      g_q     <= g_d;
      w_q     <= w_d;
      p_q     <= p_d;
    end
  end

  // A zero beat count is folded to one beat here, so LOAD never sees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q    <= '0;
      height_q    <= '0;
      groups_q    <= '0;
      pixels_q    <= '0;
      last_beat_q <= '0;
      pool_q      <= 1'b0;
      wgt_sel_q   <= '0;
    end else if (accept_start) begin
      enable_q    <= cfg_enable;
      height_q    <= cfg_height;
      groups_q    <= cfg_groups;
      pixels_q    <= cfg_pixels;
      last_beat_q <= (cfg_load_beats == 4'd0) ? 4'd0 : cfg_load_beats - 4'd1;
      pool_q      <= cfg_pool;
      wgt_sel_q   <= cfg_wgt_sel;
    end
  end

  // NOTE: every signal written here gets a default first; a path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    g_d         = g_q;
    w_d         = w_q;
    p_d         = p_q;
    instruction = '0;
    core_data   = '0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CFG;
      end

      S_CFG: begin
        instruction[15] = 1'b1;
        instruction[8]  = 1'b1;
        core_data       = {13'b0, height_q, enable_q};
        state_d         = S_BIAS;
      end

      S_BIAS: begin
        in_ready        = 1'b1;
        core_data       = in_data;
        instruction[11] = in_valid;
        if (in_xfer) begin
          if (k_q == 4'd1) begin
            k_d     = '0;
            state_d = S_CLR;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end

      S_CLR: begin
        instruction[0] = 1'b1;
        state_d        = S_LOAD;
      end

      S_LOAD: begin
        in_ready  = 1'b1;
        core_data = in_data;
        // Without a transfer the core sees a NOP and the beat is not counted.
        if (in_xfer) begin
          instruction[15]    = 1'b1;
          instruction[16]    = k_q[0];
          instruction[19:17] = wgt_sel_q;
          if (k_q == last_beat_q) begin
            k_d     = '0;
            state_d = S_ACC;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end

      S_ACC: begin
        instruction[9]   = 1'b1;
        instruction[4:1] = g_q;
        if (g_q == groups_q) begin
          g_d     = '0;
          state_d = S_BIN;
        end else begin
          g_d = g_q + 4'd1;
        end
      end

      S_BIN: begin
        instruction[10] = 1'b1;
        instruction[12] = pool_q;
        instruction[13] = w_q[0];
        instruction[6]  = w_q[1];
        if (pool_q && (w_q != 2'd3)) begin
          w_d     = w_q + 2'd1;
          state_d = S_CLR;
        end else begin
          w_d = '0;
          if (p_q == pixels_q) begin
            p_d     = '0;
            state_d = S_STORE;
          end else begin
            p_d     = p_q + 3'd1;
            state_d = S_CLR;
          end
        end
      end

      S_STORE: begin
        out_valid       = 1'b1;
        instruction[14] = 1'b1;
        instruction[6]  = k_q[0];
        if (out_ready) begin
          if (k_q[0]) begin
            k_d     = '0;
            state_d = S_DONE;
          end else begin
            k_d = 4'd1;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Self-checking bench for bnn_layer_sequencer: a step-list model built from
// the layer configuration is replayed against the DUT under random stalls.
module tb_bnn_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_enable;
  logic [2:0]  cfg_height;
  logic [3:0]  cfg_groups;
  logic [2:0]  cfg_pixels;
  logic [3:0]  cfg_load_beats;
  logic        cfg_pool;
  logic [2:0]  cfg_wgt_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] core_data;
  logic [19:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  bnn_layer_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_enable     (cfg_enable),
    .cfg_height     (cfg_height),
    .cfg_groups     (cfg_groups),
    .cfg_pixels     (cfg_pixels),
    .cfg_load_beats (cfg_load_beats),
    .cfg_pool       (cfg_pool),
    .cfg_wgt_sel    (cfg_wgt_sel),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .core_data      (core_data),
    .instruction    (instruction),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done)
  );

  // A step is one instruction the core must receive: fixed steps take one
  // cycle, stream steps wait for in_valid, output steps wait for out_ready.
  typedef enum {K_FIXED, K_STREAM, K_OUT} kind_e;
  typedef struct {
    kind_e       kind;
    logic [19:0] instr;
    logic [31:0] data;
  } step_t;

  step_t steps[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_cfg();
    cfg_enable     = 16'($urandom);
    cfg_height     = 3'($urandom);
    cfg_groups     = 4'($urandom);
    cfg_pixels     = 3'($urandom);
    cfg_load_beats = 4'($urandom);
    cfg_pool       = 1'($urandom);
    cfg_wgt_sel    = 3'($urandom);
  endtask

  function automatic void build_model(input logic [15:0] en, input logic [2:0] ht,
                                      input logic [3:0] grp, input logic [2:0] pix,
                                      input logic [3:0] lb, input logic pool,
                                      input logic [2:0] ws);
    logic [19:0] ins;
    int          n_l;
    step_t       st;
    steps.delete();
    st = '{K_FIXED, 20'h08100, {13'b0, ht, en}};
    steps.push_back(st);
    st = '{K_STREAM, 20'h00800, 32'h0};
    steps.push_back(st);
    steps.push_back(st);
    n_l = (lb == 4'd0) ? 1 : int'(lb);
    for (int p = 0; p <= int'(pix); p++) begin
      for (int w = 0; w < (pool ? 4 : 1); w++) begin
        st = '{K_FIXED, 20'h00001, 32'h0};
        steps.push_back(st);
        for (int k = 0; k < n_l; k++) begin
          ins        = 20'h08000;
          ins[16]    = k[0];
          ins[19:17] = ws;
          st = '{K_STREAM, ins, 32'h0};
          steps.push_back(st);
        end
        for (int g = 0; g <= int'(grp); g++) begin
          ins      = 20'h00200;
          ins[4:1] = 4'(g);
          st = '{K_FIXED, ins, 32'h0};
          steps.push_back(st);
        end
        ins     = 20'h00400;
        ins[12] = pool;
        ins[13] = w[0];
        ins[6]  = w[1];
        st = '{K_FIXED, ins, 32'h0};
        steps.push_back(st);
      end
    end
    st = '{K_OUT, 20'h04000, 32'h0};
    steps.push_back(st);
    st = '{K_OUT, 20'h04040, 32'h0};
    steps.push_back(st);
  endfunction

  // Entered and left at posedge+1 with the DUT idle (or aborted by reset).
  task automatic run_pass(input logic [15:0] en, input logic [2:0] ht, input logic [3:0] grp,
                          input logic [2:0] pix, input logic [3:0] lb, input logic pool,
                          input logic [2:0] ws, input bit stall, input int out_hold,
                          input bit abort_acc, input bit glitch);
    step_t       s;
    int          idx, stalls, hold, busy_cnt, loads;
    int          n_p, n_w, n_l, n_g;
    bit          adv;
    logic [19:0] exp_ins;
    logic [31:0] exp_dat;

    n_p = int'(pix) + 1;
    n_w = pool ? 4 : 1;
    n_l = (lb == 4'd0) ? 1 : int'(lb);
    n_g = int'(grp) + 1;
    build_model(en, ht, grp, pix, lb, pool, ws);

    cfg_enable = en; cfg_height = ht; cfg_groups = grp; cfg_pixels = pix;
    cfg_load_beats = lb; cfg_pool = pool; cfg_wgt_sel = ws;
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    check("idle_instr", 32'(instruction), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    start = 1'b0;

    idx = 0; stalls = 0; hold = out_hold; busy_cnt = 0; loads = 0;
    while (idx < steps.size()) begin
      s         = steps[idx];
      in_data   = $urandom;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      if (s.kind == K_STREAM)
        in_valid = (!stall || stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
      if (s.kind == K_OUT) begin
        if (hold > 0) begin
          out_ready = 1'b0;
          hold--;
        end else begin
          out_ready = (!stall || stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        end
      end
      start = glitch && (s.kind == K_FIXED) && s.instr[10];
      randomize_cfg();
      if (abort_acc && (s.kind == K_FIXED) && s.instr[9]) rst = 1'b1;

      @(negedge clk);
      exp_ins = (s.kind == K_STREAM && !in_valid) ? 20'h0 : s.instr;
      exp_dat = (s.kind == K_STREAM) ? in_data : s.data;
      check($sformatf("instr[%0d]", idx), 32'(instruction), 32'(exp_ins));
      check($sformatf("data[%0d]", idx), core_data, exp_dat);
      check($sformatf("in_ready[%0d]", idx), 32'(in_ready), 32'(s.kind == K_STREAM));
      check($sformatf("out_valid[%0d]", idx), 32'(out_valid), 32'(s.kind == K_OUT));
      check($sformatf("busy[%0d]", idx), 32'(busy), 32'h1);
      check($sformatf("done_early[%0d]", idx), 32'(done), 32'h0);
      if (busy) busy_cnt++;
      if (in_valid && in_ready && instruction[15]) loads++;
      adv = (s.kind == K_FIXED) || (s.kind == K_STREAM && in_valid) ||
            (s.kind == K_OUT && out_ready);

      @(posedge clk); #1;
      if (rst) begin
        rst   = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("abort_instr", 32'(instruction), 32'h0);
          check("abort_data", core_data, 32'h0);
          check("abort_flags", {28'h0, busy, done, in_ready, out_valid}, 32'h0);
          @(posedge clk); #1;
        end
        return;
      end
      if (adv) begin
        idx++;
        stalls = 0;
      end else begin
        stalls++;
      end
    end

    start = 1'b0;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'h1);
    check("done_busy", 32'(busy), 32'h1);
    check("done_instr", 32'(instruction), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_done", 32'(done), 32'h0);
    check("post_busy", 32'(busy), 32'h0);
    check("post_instr", 32'(instruction), 32'h0);
    @(posedge clk); #1;
    check("load_transfers", 32'(loads), 32'(n_p * n_w * n_l));
    if (!stall && out_hold == 0)
      check("pass_cycles", 32'(busy_cnt), 32'(1 + 2 + n_p * n_w * (1 + n_l + n_g + 1) + 2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    cfg_enable = '0; cfg_height = '0; cfg_groups = '0; cfg_pixels = '0;
    cfg_load_beats = '0; cfg_pool = 1'b0; cfg_wgt_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_instr", 32'(instruction), 32'h0);
    check("rst_data", core_data, 32'h0);
    check("rst_flags", {28'h0, busy, done, in_ready, out_valid}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two pixels, no pooling, three load beats, two groups, no stalls.
    run_pass(16'hA5C3, 3'd5, 4'd1, 3'd1, 4'd3, 1'b0, 3'd0, 1'b0, 0, 1'b0, 1'b0);
    // Pooling over one pixel: four windows, each preceded by CLR.
    run_pass(16'h1234, 3'd2, 4'd0, 3'd0, 4'd2, 1'b1, 3'd6, 1'b0, 0, 1'b0, 1'b0);
    // Random in_valid/out_ready stalls.
    run_pass(16'hFFFF, 3'd7, 4'd2, 3'd2, 4'd4, 1'b0, 3'd3, 1'b1, 0, 1'b0, 1'b0);
    // out_ready held low five cycles on the first STORE half.
    run_pass(16'h0F0F, 3'd1, 4'd1, 3'd0, 4'd1, 1'b0, 3'd2, 1'b0, 5, 1'b0, 1'b0);
    // Reset during ACC, then a full pass.
    run_pass(16'h8001, 3'd3, 4'd3, 3'd1, 4'd2, 1'b0, 3'd1, 1'b0, 0, 1'b1, 1'b0);
    run_pass(16'h7E7E, 3'd4, 4'd2, 3'd1, 4'd2, 1'b1, 3'd5, 1'b0, 0, 1'b0, 1'b0);
    // start pulsed at every BIN must be ignored.
    run_pass(16'h3C3C, 3'd6, 4'd1, 3'd2, 4'd2, 1'b0, 3'd7, 1'b0, 0, 1'b0, 1'b1);
    // Zero load beats behave as one beat; largest beat and group counts.
    run_pass(16'h00FF, 3'd0, 4'd0, 3'd0, 4'd0, 1'b0, 3'd4, 1'b0, 0, 1'b0, 1'b0);
    run_pass(16'hF00D, 3'd2, 4'd15, 3'd0, 4'd15, 1'b0, 3'd2, 1'b0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 5; t++)
      run_pass(16'($urandom), 3'($urandom), 4'($urandom), 3'($urandom),
               4'($urandom), 1'($urandom), 3'($urandom), 1'b1, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
